io_rx_fifo: RTL and testbench
=============================

Name: io_rx_fifo

Overview:
Receive-side byte buffer that sits between the UART receiver and the CPU memory map. It accepts bytes from the receiver through a valid/ready handshake. It presents the oldest byte to the memory map as DataOut/DataOutValid and pops it when the memory map asserts DataOutReady during an lw from 0x8000000C. This decouples serial arrival from CPU polling, so bytes are not lost while software is busy.

Parameters:
DEPTH, 8, number of byte entries; power of two, minimum 2.
ADDR_W, 3, pointer width; equals log2(DEPTH).

Ports:
Clock  input  1  system clock; all state updates on the rising edge.
Reset  input  1  synchronous, active-high reset.
RxData  input  8  byte from the UART receiver.
RxValid  input  1  RxData holds a valid byte this cycle.
RxReady  output  1  FIFO can accept a byte this cycle.
DataOut  output  8  head byte, to the memory map.
DataOutValid  output  1  FIFO is non-empty, so DataOut is valid.
DataOutReady  input  1  pop request from the memory map.
Full  output  1  occupancy equals DEPTH.
Count  output  ADDR_W+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset: one clock and a synchronous, active-high reset; ports are named Clock and Reset.
  - While Reset is high at a rising edge: read pointer, write pointer and Count go to 0.
  - Outputs after that edge: DataOutValid=0, Full=0, RxReady=1, DataOut=8'h00.
  - While Reset is asserted, RxReady=0 and pops are ignored.
- Reset mid-operation: all stored bytes are discarded. Storage RAM contents need not be cleared; they are masked by Count=0.
- Push: occurs on an edge when RxValid && RxReady. RxData is written at the write pointer, and the write pointer increments modulo DEPTH.
- Ready rule: RxReady = !Full && !Reset, combinational from registered state only. It does not depend on DataOutReady, so there is no pass-through when full.
- Pop: occurs on an edge when DataOutReady && DataOutValid. The read pointer increments modulo DEPTH. DataOutReady while empty is ignored and leaves no side effect.
- First-word-fall-through:
  - DataOut = storage[read pointer] whenever DataOutValid=1, and 8'h00 when empty.
  - DataOutValid = (Count != 0), registered state only.
- Latency:
  - A byte pushed at edge N appears on DataOut with DataOutValid=1 in the cycle after edge N, if the FIFO was empty.
  - A pop at edge N presents the next byte, or Valid=0, in the cycle after edge N.
- Count update per edge:
  - push only: +1
  - pop only: −1
  - both, or neither: unchanged
- Simultaneous push and pop with Count in 1..DEPTH−1: both are performed; pointers advance independently.
- Simultaneous push and pop when empty: the push is performed and the pop is ignored; Count becomes 1.
- Full: Full = (Count == DEPTH). When full, the push is refused; a pop in the same cycle frees an entry for the next cycle.
- Wrap-around: pointers are ADDR_W bits wide and wrap from DEPTH−1 to 0. Full and empty are distinguished by Count, not by pointer equality.
- DataOutReady is a single-cycle level. If it stays high for k cycles, k pops occur, one per cycle while non-empty.
- No X is ever driven on any output, including after reset.

Optional Feature:
IO_RX_FIFO_OVERRUN_EN
- Defined: adds two ports, each with the following behaviour.
  - OverrunCount, output, 8 bits: a saturating counter. It increments on each edge where RxValid && !RxReady && !Reset, and holds at 8'hFF.
  - OverrunClear, input, 1 bit: clears the counter to 0 at the edge, with priority over increment. Reset also clears it.
- Not defined: neither port exists, refused bytes are silently dropped by the receiver, and no other behaviour changes.

Test Plan:
- Reset, then idle 3 cycles -> RxReady=1, DataOutValid=0, DataOut=8'h00, Count=0, Full=0.
- Push 8'h41 at edge N, DataOutReady=0 -> cycle after N: DataOutValid=1, DataOut=8'h41, Count=1. Pulse DataOutReady for 1 cycle -> DataOutValid=0, Count=0.
- Push 8'h00..8'h07 back-to-back (DEPTH=8) -> Full=1, RxReady=0, Count=8.
  - Offer 8'hAA -> refused, Count stays 8; with IO_RX_FIFO_OVERRUN_EN, OverrunCount=1.
  - Pop all -> read order 00..07, exact.
- Wrap: push 6, pop 6, push 8'h10..8'h15, pop 6 -> order 10..15, pointers wrapped past index 7, Count=0 at end.
- Simultaneous push/pop:
  - With Count=3 and head 8'h20, push 8'h30 while popping -> Count=3, next head is the second byte, 8'h30 is last.
  - With Count=0, push+pop -> Count=1.
- Reset asserted with Count=5 -> next cycle Count=0, DataOutValid=0. The first push after reset, 8'h55, is the head, with no stale data.

Source files
------------

// File: rtl/io_rx_fifo.sv
// Receive byte FIFO, first-word-fall-through: a byte pushed into an empty FIFO is visible the cycle after the push.
// RxReady drops only when full, and there is no pass-through when full; IO_RX_FIFO_OVERRUN_EN adds a refused-byte counter.
module io_rx_fifo #(
  parameter int DEPTH  = 8,
  parameter int ADDR_W = 3
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic [7:0]        RxData,
  input  logic              RxValid,
  output logic              RxReady,
  output logic [7:0]        DataOut,
  output logic              DataOutValid,
  input  logic              DataOutReady,
  output logic              Full,
  output logic [ADDR_W:0]   Count
`ifdef IO_RX_FIFO_OVERRUN_EN
  ,
  output logic [7:0]        OverrunCount,
  input  logic              OverrunClear
`endif
);

  localparam logic [ADDR_W-1:0] PTR_ONE  = ADDR_W'(1);
  localparam logic [ADDR_W:0]   CNT_ONE  = (ADDR_W + 1)'(1);
  localparam logic [ADDR_W:0]   CNT_FULL = (ADDR_W + 1)'(DEPTH);

  logic [7:0]        mem_q [DEPTH];
  logic [ADDR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [ADDR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [ADDR_W:0]   count_q, count_d;
  logic              push, pop, full, not_empty;

  assign full         = (count_q == CNT_FULL);
  assign not_empty    = (count_q != '0);
  assign Full         = full;
  assign Count        = count_q;
  assign DataOutValid = not_empty;
  assign RxReady      = !full && !Reset;
  // Stale RAM contents stay hidden behind the occupancy count.
  assign DataOut      = not_empty ? mem_q[rd_ptr_q] : 8'h00;

  always_comb begin
    push     = RxValid && !full && !Reset;
    pop      = DataOutReady && not_empty && !Reset;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push) wr_ptr_d = wr_ptr_q + PTR_ONE;
    if (pop)  rd_ptr_d = rd_ptr_q + PTR_ONE;
    case ({push, pop})
      2'b10:   count_d = count_q + CNT_ONE;
      2'b01:   count_d = count_q - CNT_ONE;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge Clock) begin
    if (Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
    end
  end

  always_ff @(posedge Clock) begin
    if (push) mem_q[wr_ptr_q] <= RxData;
  end

`ifdef IO_RX_FIFO_OVERRUN_EN
  logic [7:0] ovr_q, ovr_d;

  always_comb begin
    ovr_d = ovr_q;
    if (OverrunClear) ovr_d = 8'h00;
    else if (RxValid && full && ovr_q != 8'hFF) ovr_d = ovr_q + 8'h01;
  end

  always_ff @(posedge Clock) begin
    if (Reset) ovr_q <= 8'h00;
    else       ovr_q <= ovr_d;
  end

  assign OverrunCount = ovr_q;
`endif

endmodule

// File: tb/tb_io_rx_fifo.sv
// Bench for io_rx_fifo: vector table plus hand sequences, with a queue scoreboard checked every cycle.
module tb_io_rx_fifo;

  logic       Clock = 1'b0;
  logic       Reset;
  logic [7:0] RxData;
  logic       RxValid;
  logic       RxReady;
  logic [7:0] DataOut;
  logic       DataOutValid;
  logic       DataOutReady;
  logic       Full;
  logic [3:0] Count;
  logic       OverrunClear;
`ifdef IO_RX_FIFO_OVERRUN_EN
  logic [7:0] OverrunCount;
`endif

  io_rx_fifo #(.DEPTH(8), .ADDR_W(3)) dut (
    .Clock        (Clock),
    .Reset        (Reset),
    .RxData       (RxData),
    .RxValid      (RxValid),
    .RxReady      (RxReady),
    .DataOut      (DataOut),
    .DataOutValid (DataOutValid),
    .DataOutReady (DataOutReady),
    .Full         (Full),
    .Count        (Count)
`ifdef IO_RX_FIFO_OVERRUN_EN
    ,
    .OverrunCount (OverrunCount),
    .OverrunClear (OverrunClear)
`endif
  );

  always #5 Clock = ~Clock;

  int unsigned n_checks = 0;
  int unsigned n_pass   = 0;
  logic [7:0]  sb_q[$];
  logic [7:0]  ovr_m = 8'h00;

  typedef struct {
    logic       rst;
    logic       vld;
    logic [7:0] dat;
    logic       rdy;
    logic [3:0] e_cnt;
    logic       e_vld;
    logic [7:0] e_dout;
  } vec_t;

  vec_t tbl[8];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  // Drives one cycle; checks outputs mid-cycle against the scoreboard, then advances the model at the edge.
  task automatic step(input logic rst, input logic vld, input logic [7:0] dat, input logic rdy);
    int  sz;
    logic do_push, do_pop;
    Reset = rst; RxValid = vld; RxData = dat; DataOutReady = rdy;
    @(negedge Clock);
    sz = sb_q.size();
    chk("count", 32'(Count), 32'(sz));
    chk("valid", 32'(DataOutValid), 32'(sz != 0));
    chk("full", 32'(Full), 32'(sz == 8));
    chk("rx_ready", 32'(RxReady), 32'(sz != 8 && !rst));
    chk("dout", 32'(DataOut), (sz != 0) ? 32'(sb_q[0]) : 32'h0);
`ifdef IO_RX_FIFO_OVERRUN_EN
    chk("overrun", 32'(OverrunCount), 32'(ovr_m));
`endif
    do_pop  = rdy && !rst && sz > 0;
    do_push = vld && !rst && sz < 8;
    if (do_pop) chk("pop_data", 32'(DataOut), 32'(sb_q[0]));
    @(posedge Clock);
    if (rst || OverrunClear) ovr_m = 8'h00;
    else if (vld && sz == 8 && ovr_m != 8'hFF) ovr_m = ovr_m + 8'h01;
    if (rst) sb_q.delete();
    else begin
      if (do_pop)  void'(sb_q.pop_front());
      if (do_push) sb_q.push_back(dat);
    end
    #1;
  endtask

  initial begin
    Reset = 1'b1; RxValid = 1'b0; RxData = 8'h00; DataOutReady = 1'b0; OverrunClear = 1'b0;
    @(posedge Clock); #1;

    tbl[0] = '{1'b1, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[1] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00};
    tbl[2] = '{1'b0, 1'b0, 8'h00, 1'b0, 4'd0, 1'b0, 8'h00};
    tbl[3] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[4] = '{1'b0, 1'b1, 8'h41, 1'b0, 4'd1, 1'b1, 8'h41};
    tbl[5] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 8'h00};
    tbl[6] = '{1'b0, 1'b1, 8'h5A, 1'b1, 4'd1, 1'b1, 8'h5A};
    tbl[7] = '{1'b0, 1'b0, 8'h00, 1'b1, 4'd0, 1'b0, 8'h00};
    for (int i = 0; i < 8; i++) begin
      step(tbl[i].rst, tbl[i].vld, tbl[i].dat, tbl[i].rdy);
      chk($sformatf("tbl%0d_count", i), 32'(Count), 32'(tbl[i].e_cnt));
      chk($sformatf("tbl%0d_valid", i), 32'(DataOutValid), 32'(tbl[i].e_vld));
      chk($sformatf("tbl%0d_dout", i), 32'(DataOut), 32'(tbl[i].e_dout));
    end

    // Fill to full, offer one refused byte, then drain with DataOutReady held high.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    chk("fill_full", 32'(Full), 32'h1);
    chk("fill_ready", 32'(RxReady), 32'h0);
    chk("fill_count", 32'(Count), 32'd8);
    step(1'b0, 1'b1, 8'hAA, 1'b0);
    chk("refused_count", 32'(Count), 32'd8);
`ifdef IO_RX_FIFO_OVERRUN_EN
    chk("overrun_one", 32'(OverrunCount), 32'd1);
`endif
    for (int i = 0; i < 8; i++) begin
      chk("drain_order", 32'(DataOut), 32'(i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("drain_empty", 32'(DataOutValid), 32'h0);

    // Wrap the pointers past the last index.
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'hC0 + i), 1'b0);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    for (int i = 0; i < 6; i++) step(1'b0, 1'b1, 8'(8'h10 + i), 1'b0);
    for (int i = 0; i < 6; i++) begin
      chk("wrap_order", 32'(DataOut), 32'(8'h10 + i));
      step(1'b0, 1'b0, 8'h00, 1'b1);
    end
    chk("wrap_count", 32'(Count), 32'd0);

    // Simultaneous push and pop in the middle of the range.
    step(1'b0, 1'b1, 8'h20, 1'b0);
    step(1'b0, 1'b1, 8'h21, 1'b0);
    step(1'b0, 1'b1, 8'h22, 1'b0);
    step(1'b0, 1'b1, 8'h30, 1'b1);
    chk("pp_count", 32'(Count), 32'd3);
    chk("pp_head", 32'(DataOut), 32'h21);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("pp_last", 32'(DataOut), 32'h30);
    step(1'b0, 1'b0, 8'h00, 1'b1);

    // Push while full is refused even with a pop on the same edge.
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(8'h80 + i), 1'b0);
    step(1'b0, 1'b1, 8'h99, 1'b1);
    chk("full_pp_count", 32'(Count), 32'd7);
    chk("full_pp_ready", 32'(RxReady), 32'h1);
    for (int i = 0; i < 7; i++) step(1'b0, 1'b0, 8'h00, 1'b1);
    chk("full_pp_empty", 32'(Count), 32'd0);

    // Reset mid-operation discards everything.
    for (int i = 0; i < 5; i++) step(1'b0, 1'b1, 8'(8'hE0 + i), 1'b0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
    chk("rst_count", 32'(Count), 32'd0);
    chk("rst_valid", 32'(DataOutValid), 32'h0);
    step(1'b0, 1'b1, 8'h55, 1'b0);
    chk("post_rst_head", 32'(DataOut), 32'h55);
    chk("post_rst_count", 32'(Count), 32'd1);
    step(1'b0, 1'b0, 8'h00, 1'b1);

`ifdef IO_RX_FIFO_OVERRUN_EN
    for (int i = 0; i < 8; i++) step(1'b0, 1'b1, 8'(i), 1'b0);
    for (int i = 0; i < 260; i++) step(1'b0, 1'b1, 8'hBB, 1'b0);
    chk("overrun_sat", 32'(OverrunCount), 32'hFF);
    OverrunClear = 1'b1;
    step(1'b0, 1'b1, 8'hBB, 1'b0);
    OverrunClear = 1'b0;
    chk("overrun_clear", 32'(OverrunCount), 32'h0);
    step(1'b1, 1'b0, 8'h00, 1'b0);
`endif

    step(1'b0, 1'b0, 8'h00, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
